// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for serial_adder.
// The producer side uses the master modport; the adder itself uses slave.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell with a registered carry, LSB first.
// Operands are taken and results returned over valid/ready handshakes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int            CW          = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE_MSB = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             carry_msb_reg, carry_msb_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             bit_s;
  logic             bit_c;

  assign bit_s = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign bit_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_msb_reg <= 1'b0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      sum_reg       <= sum_next;
      cnt_reg       <= cnt_next;
      carry_reg     <= carry_next;
      carry_msb_reg <= carry_msb_next;
      cout_reg      <= cout_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    sum_next       = sum_reg;
    cnt_next       = cnt_reg;
    carry_next     = carry_reg;
    carry_msb_next = carry_msb_reg;
    cout_next      = cout_reg;
    ovf_next       = ovf_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next         = bus.a;
          b_next         = bus.sub ? ~bus.b : bus.b;
          carry_next     = bus.sub;
          carry_msb_next = 1'b0;
          cnt_next       = '0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        // A doubles as the result register: sum bits enter at the top as operand bits leave the bottom.
        a_next     = {bit_s, a_reg[WIDTH-1:1]};
        b_next     = {1'b0, b_reg[WIDTH-1:1]};
        carry_next = bit_c;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CNT_PRE_MSB) begin
          carry_msb_next = bit_c;
        end
        if (cnt_reg == CNT_LAST) begin
          sum_next   = {bit_s, a_reg[WIDTH-1:1]};
          cout_next  = bit_c;
          ovf_next   = carry_msb_reg ^ bit_c;
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases on an 8-bit instance, then randomized
// back-to-back traffic with output stalls on widths 2, 8, 13 and 32.
module tb_serial_adder;
  localparam int N_OPS = 1000;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic rand_go  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(int i);
    case (i)
      0:       return 2;
      1:       return 8;
      2:       return 13;
      default: return 32;
    endcase
  endfunction

  // Reference: {overflow, cout, sum} from unsigned and signed integer arithmetic.
  function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b, logic s);
    logic [63:0] mask;
    logic [63:0] r;
    longint      sa, sb, sr, smax, smin;
    logic        c, v;
    mask = (64'd1 << w) - 64'd1;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb   = $signed(b << (64 - w)) >>> (64 - w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    if (s) begin
      r  = (a - b) & mask;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = (a + b) & mask;
      c  = ((a + b) > mask);
      sr = sa + sb;
    end
    v = (sr > smax) || (sr < smin);
    return {v, c, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // ---------------- directed 8-bit instance ----------------
  serial_adder_if #(.WIDTH(8)) dbus();
  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(dbus));

  logic [65:0] q8[$];
  logic [65:0] m8_exp;

  always @(negedge clk) begin
    if (dbus.out_valid && dbus.out_ready) begin
      if (q8.size() == 0) begin
        fail_now("dir_unexpected_output");
      end else begin
        m8_exp = q8.pop_front();
        check("dir_sum", 64'(dbus.sum), m8_exp[63:0]);
        check1("dir_cout", dbus.cout, m8_exp[64]);
        check1("dir_overflow", dbus.overflow, m8_exp[65]);
        $display("dir result sum=0x%02h cout=%0b ovf=%0b", dbus.sum, dbus.cout, dbus.overflow);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic d_issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] es, input logic ec, input logic ev);
    logic rdy;
    int   guard;
    dbus.a = a; dbus.b = b; dbus.sub = s; dbus.in_valid = 1'b1;
    guard = 0;
    do begin
      rdy = dbus.in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 200);
    dbus.in_valid = 1'b0;
    dbus.a = ~a; dbus.b = ~b; dbus.sub = ~s;
    if (!rdy) fail_now("dir_accept");
    else q8.push_back({ev, ec, 64'(es)});
  endtask

  task automatic d_drain();
    int guard;
    guard = 0;
    while ((q8.size() != 0 || dbus.out_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) fail_now("dir_drain");
  endtask

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int W = width_of(gi);
    serial_adder_if #(.WIDTH(W)) rbus();
    serial_adder #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(rbus));

    logic [65:0] exp_q[$];
    logic [65:0] mon_exp;

    initial begin : stall
      rbus.out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        rbus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin : drive
      logic [W-1:0] ra, rb;
      logic         rs, rdy;
      int           guard;
      rbus.in_valid = 1'b0; rbus.a = '0; rbus.b = '0; rbus.sub = 1'b0;
      wait (rand_go);
      @(posedge clk); #1;
      for (int n = 0; n < N_OPS; n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom);
        rbus.a = ra; rbus.b = rb; rbus.sub = rs; rbus.in_valid = 1'b1;
        guard = 0;
        do begin
          rdy = rbus.in_ready;
          @(posedge clk); #1;
          guard++;
        end while (!rdy && guard < 300);
        if (!rdy) fail_now($sformatf("w%0d_accept", W));
        else exp_q.push_back(model(W, 64'(ra), 64'(rb), rs));
      end
      rbus.in_valid = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 1000) begin
        @(posedge clk); #1;
        guard++;
      end
      if (exp_q.size() != 0) fail_now($sformatf("w%0d_drain", W));
      done_cnt++;
    end

    always @(negedge clk) begin : mon
      if (rbus.out_valid && rbus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("w%0d_unexpected_output", W));
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("w%0d_sum", W), 64'(rbus.sum), mon_exp[63:0]);
          check1($sformatf("w%0d_cout", W), rbus.cout, mon_exp[64]);
          check1($sformatf("w%0d_overflow", W), rbus.overflow, mon_exp[65]);
          $display("w%0d result sum=0x%0h cout=%0b ovf=%0b", W, rbus.sum, rbus.cout, rbus.overflow);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int guard;
    rst = 1'b0;
    dbus.in_valid = 1'b0; dbus.a = '0; dbus.b = '0; dbus.sub = 1'b0; dbus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check1("reset_in_ready", dbus.in_ready, 1'b1);
    check1("reset_out_valid", dbus.out_valid, 1'b0);
    check("reset_sum", 64'(dbus.sum), 64'h0);
    check1("reset_cout", dbus.cout, 1'b0);
    check1("reset_overflow", dbus.overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Latency: out_valid low after accept+7 edges, high after accept+8.
    dbus.out_ready = 1'b1;
    d_issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 check1("latency_before", dbus.out_valid, 1'b0);
    @(posedge clk);
    #1 check1("latency_at", dbus.out_valid, 1'b1);
    d_drain();

    d_issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); d_drain();
    d_issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); d_drain();
    d_issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0); d_drain();
    d_issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1); d_drain();

    // Backpressure with other operands offered throughout SHIFT and DONE.
    dbus.out_ready = 1'b0;
    d_issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    dbus.a = 8'hAA; dbus.b = 8'h55; dbus.sub = 1'b1; dbus.in_valid = 1'b1;
    check1("busy_in_ready", dbus.in_ready, 1'b0);
    guard = 0;
    while (!dbus.out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!dbus.out_valid) fail_now("bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      check1("bp_out_valid_hold", dbus.out_valid, 1'b1);
      check("bp_sum_hold", 64'(dbus.sum), 64'h46);
      check1("bp_in_ready", dbus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    dbus.in_valid = 1'b0;
    dbus.out_ready = 1'b1;
    @(posedge clk); #1;
    check1("hs_in_ready", dbus.in_ready, 1'b1);
    check1("hs_out_valid", dbus.out_valid, 1'b0);
    check("hs_sum_retained", 64'(dbus.sum), 64'h46);
    @(posedge clk); #1;
    check1("busy_not_taken", dbus.in_ready, 1'b1);

    // Asynchronous reset while bit 4 is being processed.
    d_issue(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check1("arst_in_ready", dbus.in_ready, 1'b1);
    check1("arst_out_valid", dbus.out_valid, 1'b0);
    check("arst_sum", 64'(dbus.sum), 64'h0);
    void'(q8.pop_back());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d_issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
    d_drain();

    rand_go = 1'b1;
    for (int c = 0; c < 80000 && done_cnt < 4; c++) @(posedge clk);
    if (done_cnt < 4) fail_now("random_regression_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial add/subtract unit and the sequential successor to the team's single-bit half adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Used where adder area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- Bit-counter width is derived internally as clog2(WIDTH); it is not a user parameter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set present on a, b, sub
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1)
- out_valid  output  1  result present on sum/cout/overflow
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, low WIDTH bits
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of clk):
  - state = IDLE; in_ready = 1; out_valid = 0; sum = 0; cout = 0; overflow = 0.
  - Shift registers, carry and counter = 0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid & in_ready:
    - Load A shift register with a.
    - Load B shift register with (sub ? ~b : b).
    - Set carry to sub; clear bit counter and result register.
    - Go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each edge:
    - s = A[0] ^ B[0] ^ carry.
    - carry <= majority(A[0], B[0], carry).
    - Result shifts right with s inserted at MSB.
    - A and B shift right; counter increments.
  - On the edge that processes bit WIDTH-2, capture the carry-out of that bit as carry_into_msb.
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
    - Register the final carry.
    - Go to DONE.
- DONE:
  - out_valid = 1.
  - sum = result register; cout = final carry; overflow = carry_into_msb ^ final carry.
  - Outputs hold stable while out_valid & !out_ready (arbitrary backpressure).
  - On an edge with out_valid & out_ready: out_valid <= 0 and go to IDLE.
  - The block accepts no new operands in the same cycle as that handshake; next accept is earliest one cycle later.
- Latency:
  - Accept at edge E0 → out_valid first high after edge E0+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles with out_ready held high.
- Handshake edge cases:
  - in_valid outside IDLE is ignored; operands are not sampled.
  - a, b and sub are sampled only at the accept edge; later changes have no effect.
- Output retention:
  - sum/cout/overflow retain their last values after the DONE handshake until the next DONE.
  - They are qualified only by out_valid.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond cout is discarded.
- Reset during SHIFT or DONE:
  - The operation is aborted and all state returns to reset values.
  - No out_valid is produced for the aborted operation.
- Widths:
  - Counter must reach WIDTH-1 without overflow for every legal WIDTH.
  - No lint width mismatches.

Test Plan:
- WIDTH=8, add 0x0F + 0x01 → sum 0x10, cout 0, overflow 0; out_valid rises exactly 8 edges after accept.
- Add 0xFF + 0x01 → sum 0x00, cout 1, overflow 0. Add 0x7F + 0x01 → sum 0x80, cout 0, overflow 1.
- Subtract 0x05 - 0x07 → sum 0xFE, cout 0, overflow 0. Subtract 0x80 - 0x01 → sum 0x7F, cout 1, overflow 1.
- Backpressure and busy behaviour:
  - Hold out_ready low for 5 cycles in DONE → out_valid and sum stay constant.
  - in_valid pulsed with different operands during SHIFT/DONE is not taken.
  - in_ready returns 1 one cycle after the output handshake.
- Assert rst asynchronously (between clk edges) at bit 4 of a SHIFT:
  - in_ready = 1 and out_valid = 0 immediately.
  - A new accept of 0x03 + 0x04 afterwards yields sum 0x07, unaffected by prior state.
- Random regression, WIDTH ∈ {2, 8, 13, 32}:
  - At least 1000 back-to-back ops with random sub and out_ready stalls.
  - Scoreboard checks sum, cout and overflow against a + (sub ? ~b+1 : b) computed at WIDTH+1 bits.
